// File: rtl/msk_sched_pkg.sv
// Shared types and helpers for the masked gadget pipeline sequencer.
package msk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int STAT_W = 32;

    // Fresh randomness bits one d-share gadget layer consumes per sharing.
    function automatic int rnd_width(input int d, input int count);
        return count * d * (d - 1) / 2;
    endfunction

endpackage

// File: rtl/msk_sched_validpipe.sv
// LAT-deep stage-valid shift register that advances only when the gadget pipeline is enabled.
module msk_sched_validpipe #(
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_din,
    output logic [LAT-1:0] o_v
);

    logic [LAT-1:0] r_v;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v <= '0;
        end else if (i_en) begin
            r_v <= (r_v << 1) | LAT'(i_din);
        end
    end

    assign o_v = r_v;

endmodule

// File: rtl/msk_gadget_sched.sv
// Sequencer for a fixed-latency masked gadget pipeline: pairs each sharing with fresh randomness.
// Optional saturating statistics counters are enabled with `define MSK_SCHED_STATS_EN.
module msk_gadget_sched
    import msk_sched_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 1,
    parameter int LAT   = 2,
    parameter int RND_W = rnd_width(d, count)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    input  logic              flush,
    output logic              pipe_en,
    output logic              issue,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              drained
`ifdef MSK_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_rnd_starve,
    output logic [STAT_W-1:0] stat_backpressure
`endif
);

    sched_state_t   r_state, w_state_nxt;
    logic           r_done, w_done_nxt;
    logic           r_flush_q;
    logic [LAT-1:0] w_v;
    logic [LAT-1:0] w_v_nxt;
    logic           w_stall, w_pipe_en, w_admit_ok, w_issue, w_empty, w_drained;

    assign w_stall    = w_v[LAT-1] & ~out_ready;
    assign w_pipe_en  = ~w_stall;
    assign w_admit_ok = (r_state != DRAIN) & ~flush & w_pipe_en;
    assign w_issue    = rst & in_valid & rnd_valid & w_admit_ok;
    assign w_v_nxt    = w_pipe_en ? ((w_v << 1) | LAT'(w_issue)) : w_v;
    assign w_empty    = (w_v == '0);
    // r_done suppresses repeat pulses while flush is held after the drain finished.
    assign w_drained  = rst & (r_state == DRAIN) & w_empty & ~r_done;

    msk_sched_validpipe #(.LAT(LAT)) u_validpipe (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pipe_en),
        .i_din(w_issue),
        .o_v  (w_v)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        case (r_state)
            IDLE:    if (flush) w_state_nxt = DRAIN;
                     else if (w_issue) w_state_nxt = RUN;
            RUN:     if (flush) w_state_nxt = DRAIN;
                     else if (w_v_nxt == '0) w_state_nxt = IDLE;
            DRAIN:   if (w_empty && !flush) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (r_state != DRAIN) w_done_nxt = 1'b0;
        else if (w_drained) w_done_nxt = 1'b1;
        else if (flush && !r_flush_q) w_done_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_flush_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_flush_q <= flush;
        end
    end

    assign issue     = w_issue;
    assign in_ready  = w_issue;
    assign rnd_ready = w_issue;
    assign pipe_en   = rst & w_pipe_en;
    assign out_valid = rst & w_v[LAT-1];
    assign busy      = rst & (~w_empty | (r_state != IDLE));
    assign drained   = w_drained;

    // Both handshakes fire together, and every issued sharing consumes a nonzero randomness word.
    assert property (@(posedge clk) disable iff (!rst) (in_ready == rnd_ready) && (!issue || RND_W > 0));

`ifdef MSK_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stat_issued, r_stat_starve, r_stat_bp;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_issued <= '0;
            r_stat_starve <= '0;
            r_stat_bp     <= '0;
        end else begin
            r_stat_issued <= sat_inc(r_stat_issued, w_issue);
            r_stat_starve <= sat_inc(r_stat_starve, in_valid & w_admit_ok & ~rnd_valid);
            r_stat_bp     <= sat_inc(r_stat_bp, w_stall);
        end
    end

    assign stat_issued       = r_stat_issued;
    assign stat_rnd_starve   = r_stat_starve;
    assign stat_backpressure = r_stat_bp;
`endif

endmodule

// File: tb/tb_msk_gadget_sched.sv
// Scoreboard bench for msk_gadget_sched: behavioural in-flight model plus directed and random stimulus.
module tb_msk_gadget_sched;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, rnd_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic in_ready, rnd_ready, pipe_en, issue, out_valid, busy, drained;
`ifdef MSK_SCHED_STATS_EN
    logic [31:0] stat_issued, stat_rnd_starve, stat_backpressure;
`endif

    msk_gadget_sched #(.d(2), .count(1), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .flush    (flush),
        .pipe_en  (pipe_en),
        .issue    (issue),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .drained  (drained)
`ifdef MSK_SCHED_STATS_EN
        ,
        .stat_issued      (stat_issued),
        .stat_rnd_starve  (stat_rnd_starve),
        .stat_backpressure(stat_backpressure)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: each in-flight sharing carries the number of enabled edges since issue.
    int     ages[$];
    int     mode = 0;          // 0 idle, 1 run, 2 drain
    bit     pulsed = 0, flush_q = 0;
    longint en_edges = 0;
    longint sb[$];
    int     m_issued = 0, m_starve = 0, m_bp = 0;
    bit     e_stall, e_admit, e_issue, e_ov, e_busy, e_drained;
    int     dut_issues = 0, dut_drains = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, then compare.
    always @(negedge clk) begin
        bit has_out;
        has_out = 0;
        foreach (ages[i]) if (ages[i] == LAT) has_out = 1;
        if (!rst) begin
            e_ov = 0; e_stall = 0; e_admit = 0; e_issue = 0; e_busy = 0; e_drained = 0;
        end else begin
            e_ov      = has_out;
            e_stall   = has_out & ~out_ready;
            e_admit   = (mode != 2) & ~flush & ~e_stall;
            e_issue   = in_valid & rnd_valid & e_admit;
            e_busy    = (ages.size() > 0) || (mode != 0);
            e_drained = (mode == 2) && (ages.size() == 0) && !pulsed;
        end
        check("ctl{ir,rr,iss,en,ov,busy,drn}",
              {57'd0, in_ready, rnd_ready, issue, pipe_en, out_valid, busy, drained},
              {57'd0, e_issue, e_issue, e_issue, rst & ~e_stall, e_ov, e_busy, e_drained});
`ifdef MSK_SCHED_STATS_EN
        check("stat_issued", 64'(stat_issued), 64'(m_issued));
        check("stat_rnd_starve", 64'(stat_rnd_starve), 64'(m_starve));
        check("stat_backpressure", 64'(stat_backpressure), 64'(m_bp));
`endif
        if (e_issue) sb.push_back(en_edges);
    end

    // Monitor: every delivered result must have spent exactly LAT enabled cycles in the pipe.
    always @(negedge clk) begin
        longint t;
        if (rst && issue) dut_issues++;
        if (rst && drained) dut_drains++;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL deliver: out_valid with nothing expected in flight at %0t", $time);
            end else begin
                t = sb.pop_front();
                check("latency", 64'(en_edges - t), 64'(LAT));
            end
        end
    end

    // Model state advance at the clock edge.
    always @(posedge clk) begin
        bit was_empty;
        if (!rst) begin
            ages.delete();
            sb.delete();
            mode = 0; pulsed = 0; flush_q = 0;
            m_issued = 0; m_starve = 0; m_bp = 0;
        end else begin
            was_empty = (ages.size() == 0);
            if (e_issue && m_issued != -1) m_issued++;
            if (in_valid && e_admit && !rnd_valid) m_starve++;
            if (e_stall) m_bp++;
            if (!e_stall) begin
                en_edges++;
                for (int i = ages.size() - 1; i >= 0; i--) if (ages[i] == LAT) ages.delete(i);
                foreach (ages[i]) ages[i]++;
                if (e_issue) ages.push_back(1);
            end
            if (mode != 2) pulsed = 0;
            else if (e_drained) pulsed = 1;
            else if (flush && !flush_q) pulsed = 0;
            case (mode)
                0: if (flush) mode = 2; else if (e_issue) mode = 1;
                1: if (flush) mode = 2; else if (ages.size() == 0) mode = 0;
                default: if (was_empty && !flush) mode = 0;
            endcase
            flush_q = flush;
        end
    end

    task automatic drive(input bit iv, input bit rv, input bit fl, input bit ordy, input int n);
        in_valid = iv; rnd_valid = rv; flush = fl; out_ready = ordy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        rst = 1'b0;
        drive(0, 0, 0, 1, 3);
        rst = 1'b1;

        base = dut_issues;
        drive(1, 1, 0, 1, 5);
        drive(0, 0, 0, 1, 4);
        check("burst5 issues", 64'(dut_issues - base), 64'd5);

        base = dut_issues;
        for (int i = 0; i < 4; i++) drive(1, (i % 2) == 0, 0, 1, 1);
        drive(0, 0, 0, 1, 4);
        check("rnd toggle issues", 64'(dut_issues - base), 64'd2);

        base = dut_issues;
        drive(1, 1, 0, 0, 5);
        drive(0, 0, 0, 1, 4);
        check("backpressure issues", 64'(dut_issues - base), 64'd2);

        base = dut_drains;
        drive(1, 1, 0, 1, 2);
        drive(1, 1, 1, 1, 5);
        drive(0, 0, 0, 1, 3);
        check("flush drain pulses", 64'(dut_drains - base), 64'd1);

        drive(1, 1, 0, 1, 3);
        rst = 1'b0;
        drive(0, 0, 0, 1, 2);
        rst = 1'b1;
        drive(0, 0, 0, 1, 4);

        base = dut_issues;
        drive(1, 0, 0, 1, 10);
        check("starve issues", 64'(dut_issues - base), 64'd0);
        drive(0, 0, 0, 1, 2);

        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 14) == 0) flush = ~flush;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, flush,
                  $urandom_range(0, 9) < 7, 1);
        end

        rst = 1'b1;
        drive(0, 0, 0, 1, 10);
        check("scoreboard empty", 64'(sb.size()), 64'd0);
        check("idle busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msk_gadget_sched.md
Name: msk_gadget_sched

Overview:
- Sequencer for a fixed-latency masked gadget pipeline, such as a chain of masked AND/XOR/XNOR gadgets, with LAT register stages.
- Admits sharings on a valid/ready handshake and pairs each admitted sharing with one fresh randomness word from the PRNG handshake.
- Drives a single pipeline enable, tracks per-stage validity and presents results on a valid/ready output.
- Never issues a sharing without fresh randomness, so a missing randomness word inserts a bubble; randomness is never reused.

Parameters:
- d, 2, number of shares.
- count, 1, parallel masked bits per sharing.
- LAT, 2, gadget pipeline depth in register stages (≥1).
- RND_W, count*d*(d-1)/2, randomness bits consumed per admitted sharing.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream sharing valid.
- in_ready  out  1  sharing accepted this cycle when high with in_valid.
- rnd_valid  in  1  PRNG word available.
- rnd_ready  out  1  PRNG word consumed this cycle.
- flush  in  1  level request: stop admitting and drain.
- pipe_en  out  1  enable to every gadget pipeline register.
- issue  out  1  a sharing and a randomness word enter stage 0 this cycle.
- out_valid  out  1  result at the last stage is valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  at least one valid in flight, or state != IDLE.
- drained  out  1  one-cycle pulse when DRAIN completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. While rst=0 all outputs are 0, the stage-valid vector v[LAT-1:0] is 0 and state=IDLE.
- stall = v[LAT-1] & ~out_ready. pipe_en = ~stall.
- admit_ok = (state != DRAIN) & ~flush & pipe_en.
- issue = in_valid & rnd_valid & admit_ok. in_ready = rnd_ready = issue.
  - Both handshakes complete in the same cycle, always.
  - in_valid without rnd_valid gives no handshake on either side; the same holds for the reverse.
- When pipe_en=1: v shifts, with v[0] <= issue and v[i] <= v[i-1]. When pipe_en=0: v holds.
- out_valid = v[LAT-1]. Latency from issue to out_valid is exactly LAT cycles absent stalls.
- Bubbles: when pipe_en=1 and issue=0, v[0] <= 0. The gadget still clocks, but its output is marked invalid.
- States:
  - IDLE: v==0. issue goes to RUN. flush goes to DRAIN, which then completes in 1 cycle.
  - RUN: normal operation. flush goes to DRAIN. v becomes 0 with no issue, which goes to IDLE.
  - DRAIN: no admission. Once v==0, pulse drained for 1 cycle, then go to IDLE if flush=0, else stay in DRAIN and pulse again only after a new flush rising edge.
- Simultaneous issue and flush: flush wins and there is no issue.
- Simultaneous stall and in_valid/rnd_valid: no handshake.
- When rst is asserted mid-operation, in-flight results are discarded, with no out_valid the next cycle.
- busy = |v | (state != IDLE).
- Invariant: the number of rnd_ready pulses equals the number of in_ready pulses (checked by assertion).

Optional Feature:
- Macro MSK_SCHED_STATS_EN.
- When defined, it adds three outputs, each 32 bits, saturating, and cleared by reset:
  - stat_issued: number of issues.
  - stat_rnd_starve: cycles with in_valid & admit_ok & ~rnd_valid.
  - stat_backpressure: cycles with stall=1.
- When undefined, these ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package msk_sched_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the function rnd_width(d, count);
  - the constant STAT_W=32.
- One sub-module, msk_sched_validpipe: an LAT-deep valid shift register with enable, outputting v.
- The FSM, the handshake logic and the stats counters live in the top module.

Test Plan:
- LAT=2: in_valid=rnd_valid=out_ready=1 for 5 cycles gives 5 issues; out_valid is high 2 cycles after the first issue and stays high 5 cycles; stat_issued=5.
- rnd_valid toggling 1,0,1,0 with in_valid=1 gives issues only in cycles 0 and 2; out_valid follows the same pattern delayed by LAT; stat_rnd_starve=2.
- Pipe full with out_ready=0 for 3 cycles gives pipe_en=0, in_ready=0, out_valid held and v unchanged; after out_ready=1, the results appear in order.
- flush asserted during RUN with 2 in flight gives no admission; drained pulses once, 2 cycles later with out_ready=1; state returns to IDLE after flush drops.
- rst=0 mid-stream with v=2'b11 gives out_valid=0 and busy=0 on the next edge; no spurious output after rst=1.
- in_valid=1, rnd_valid=0 for 10 cycles gives in_ready=rnd_ready=0 throughout and busy=0.
